sdio_cmdseq: RTL and testbench

//  Wishbone bus-master command sequencer sitting directly upstream of the SDIO

---
 rtl/sdio_pkg.sv | 18 +
 rtl/sdio_wbm_single.sv | 61 ++++++
 rtl/sdio_cmdseq.sv | 185 ++++++++++++++++++
 tb/tb_sdio_cmdseq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_pkg.sv
// Shared definitions for the SDIO command sequencer: controller register map,
// flag positions in the CMD readback and response status codes.
package sdio_pkg;

    localparam logic [2:0] REG_CMD = 3'd0;
    localparam logic [2:0] REG_ARG = 3'd1;

    localparam int unsigned BIT_BUSY = 14;
    localparam int unsigned BIT_ERR  = 15;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_CMDERR  = 2'd1,
        RSP_TIMEOUT = 2'd2,
        RSP_BUSERR  = 2'd3
    } rsp_status_t;

endpackage

// File: rtl/sdio_wbm_single.sv
// Single-transaction Wishbone master: one read or write per start pulse,
// reporting completion with a one-cycle done pulse.
module sdio_wbm_single (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic [31:0] wb_rdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!wb_cyc) begin
                // start is ignored while a cycle is open; caller waits for done
                if (start) begin
                    wb_cyc  <= 1'b1;
                    wb_stb  <= 1'b1;
                    wb_we   <= we;
                    wb_addr <= addr;
                    wb_data <= wdata;
                end
            end else begin
                if (wb_stb && !wb_stall) begin
                    wb_stb <= 1'b0;
                end
                if (wb_ack || wb_err) begin
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                    done   <= 1'b1;
                    err    <= wb_err;
                    rdata  <= wb_err ? '0 : wb_rdata;
                end
            end
        end
    end

endmodule

// File: rtl/sdio_cmdseq.sv
// SD command sequencer: writes ARG then CMD to the SDIO controller, polls CMD
// until busy clears, reads the R1 response and hands back {data, status}.
module sdio_cmdseq
    import sdio_pkg::*;
#(
    parameter int unsigned MW        = 32,
    parameter logic [2:0]  ADDR_CMD  = REG_CMD,
    parameter logic [2:0]  ADDR_ARG  = REG_ARG,
    parameter int unsigned BUSY_BIT  = BIT_BUSY,
    parameter int unsigned ERR_BIT   = BIT_ERR,
    parameter int unsigned LGTIMEOUT = 20,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [MW-1:0] i_req_cmd,
    input  logic [MW-1:0] i_req_arg,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [MW-1:0] o_rsp_data,
    output logic [1:0]    o_rsp_status,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [2:0]    o_wb_addr,
    output logic [MW-1:0] o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [MW-1:0] i_wb_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_ARG = 3'd1;
    localparam logic [2:0] S_WR_CMD = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_RD_RSP = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    logic [2:0]         state;
    logic [MW-1:0]      cmd_word;
    logic [LGTIMEOUT:0] tmo_cnt;
    logic [GW-1:0]      gap_cnt;

    logic          wb_start, wb_we, wb_done, wb_err;
    logic [2:0]    wb_addr;
    logic [MW-1:0] wb_wdata, wb_rdata;

    logic tmo_hit, gap_done, rd_busy, rd_err;

    assign tmo_hit     = tmo_cnt[LGTIMEOUT];
    assign gap_done    = (gap_cnt == GW'(POLL_GAP - 1));
    assign rd_busy     = wb_rdata[BUSY_BIT];
    assign rd_err      = wb_rdata[ERR_BIT];
    assign o_req_ready = (state == S_IDLE);
    assign o_wb_sel    = 4'hf;

    // The ARG write is launched on the accept edge straight from the request
    // port; the master captures it, so only the command word is held here.
    always_comb begin
        wb_start = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = ADDR_CMD;
        wb_wdata = '0;
        case (state)
            S_IDLE: if (i_req_valid) begin
                wb_start = 1'b1;
                wb_we    = 1'b1;
                wb_addr  = ADDR_ARG;
                wb_wdata = i_req_arg;
            end
            S_WR_ARG: if (wb_done && !wb_err) begin
                wb_start = 1'b1;
                wb_we    = 1'b1;
                wb_wdata = cmd_word;
            end
            S_WR_CMD: wb_start = wb_done && !wb_err;
            S_POLL: if (wb_done && !wb_err && !rd_busy && !rd_err) begin
                wb_start = 1'b1;
                wb_addr  = ADDR_ARG;
            end
            S_GAP:   wb_start = !tmo_hit && gap_done;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            cmd_word     <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_status <= RSP_OK;
        end else begin
            // Saturates at the MSB so a long stalled poll cannot wrap it
            if ((state == S_POLL || state == S_GAP) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (wb_done && wb_err) begin
                state        <= S_RESP;
                o_rsp_valid  <= 1'b1;
                o_rsp_data   <= '0;
                o_rsp_status <= RSP_BUSERR;
            end else begin
                case (state)
                    S_IDLE: if (i_req_valid) begin
                        cmd_word <= i_req_cmd;
                        state    <= S_WR_ARG;
                    end
                    S_WR_ARG: if (wb_done) state <= S_WR_CMD;
                    S_WR_CMD: if (wb_done) begin
                        tmo_cnt <= '0;
                        state   <= S_POLL;
                    end
                    S_POLL: if (wb_done) begin
                        if (rd_busy) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else if (rd_err) begin
                            state        <= S_RESP;
                            o_rsp_valid  <= 1'b1;
                            o_rsp_data   <= '0;
                            o_rsp_status <= RSP_CMDERR;
                        end else begin
                            state <= S_RD_RSP;
                        end
                    end
                    S_GAP: begin
                        if (tmo_hit) begin
                            state        <= S_RESP;
                            o_rsp_valid  <= 1'b1;
                            o_rsp_data   <= '0;
                            o_rsp_status <= RSP_TIMEOUT;
                        end else if (gap_done) begin
                            state <= S_POLL;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_RD_RSP: if (wb_done) begin
                        state        <= S_RESP;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_data   <= wb_rdata;
                        o_rsp_status <= RSP_OK;
                    end
                    S_RESP: if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sdio_wbm_single u_wbm (
        .clk      (i_clk),
        .rst      (i_reset),
        .start    (wb_start),
        .we       (wb_we),
        .addr     (wb_addr),
        .wdata    (wb_wdata),
        .done     (wb_done),
        .err      (wb_err),
        .rdata    (wb_rdata),
        .wb_cyc   (o_wb_cyc),
        .wb_stb   (o_wb_stb),
        .wb_we    (o_wb_we),
        .wb_addr  (o_wb_addr),
        .wb_data  (o_wb_data),
        .wb_stall (i_wb_stall),
        .wb_ack   (i_wb_ack),
        .wb_err   (i_wb_err),
        .wb_rdata (i_wb_data)
    );

endmodule

// File: tb/tb_sdio_cmdseq.sv
// Directed bench for sdio_cmdseq: a behavioural controller slave plus
// scoreboards for bus operation order and for responses.
module tb_sdio_cmdseq;
    import sdio_pkg::*;

    localparam int unsigned LGT  = 8;
    localparam int unsigned PGAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_cmd = '0;
    logic [31:0] req_arg = '0;
    logic        o_req_ready, o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_status;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic [31:0] wb_rdata = '0;

    always #5 clk = ~clk;

    sdio_cmdseq #(
        .LGTIMEOUT (LGT),
        .POLL_GAP  (PGAP)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_cmd    (req_cmd),
        .i_req_arg    (req_arg),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_status (o_rsp_status),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_wb_sel     (o_wb_sel),
        .i_wb_stall   (wb_stall),
        .i_wb_ack     (wb_ack),
        .i_wb_err     (wb_err),
        .i_wb_data    (wb_rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus block
    int          busy_polls   = 0;
    int          stall_cycles = 0;
    int          test_id      = 0;
    logic [31:0] cmd_final    = '0;
    logic [31:0] arg_rsp      = '0;
    bit          err_on_arg   = 1'b0;
    bit          ops_check    = 1'b1;
    bit          chk_en       = 1'b0;

    logic [35:0] op_q[$];   // {we, addr, write data or 0}
    logic [34:0] rsp_q[$];  // {check data, data, status}

    // Slave state, written only by the slave process
    int          polls_seen = 0;
    int          seen_id    = 0;
    int          stall_left = 0;
    int          cyc_cnt    = 0;
    int          cmd_ack_cyc = 0;
    bit          ack_pend = 1'b0;
    bit          err_pend = 1'b0;
    logic [31:0] rd_pend  = '0;
    logic        prev_stb = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_we = 1'b0;
    logic [2:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [35:0] obs_op, exp_op;

    always @(negedge clk) begin
        cyc_cnt++;
        if (test_id != seen_id) begin
            seen_id    = test_id;
            polls_seen = 0;
        end
        if (chk_en && prev_stb) begin
            if (prev_stall)
                check("stb_hold_stall", {o_wb_stb, o_wb_we, o_wb_addr, o_wb_data},
                      {1'b1, prev_we, prev_addr, prev_data});
            else
                check("stb_drop", o_wb_stb, 1'b0);
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (rst) begin
            ack_pend   = 1'b0;
            wb_stall   = 1'b0;
            stall_left = stall_cycles;
        end else begin
            if (ack_pend) begin
                ack_pend = 1'b0;
                wb_err   = err_pend;
                wb_ack   = !err_pend;
                wb_rdata = rd_pend;
            end
            if (o_wb_cyc && o_wb_stb && stall_left > 0) begin
                wb_stall = 1'b1;
                stall_left--;
            end else begin
                wb_stall = 1'b0;
                if (!o_wb_stb) stall_left = stall_cycles;
            end
            if (o_wb_cyc && o_wb_stb && !wb_stall) begin
                obs_op = {o_wb_we, o_wb_addr, o_wb_we ? o_wb_data : 32'h0};
                if (ops_check) begin
                    check("op_expected", op_q.size() > 0, 1'b1);
                    if (op_q.size() > 0) begin
                        exp_op = op_q.pop_front();
                        check("op_order", obs_op, exp_op);
                    end
                end
                ack_pend = 1'b1;
                err_pend = err_on_arg && o_wb_we && (o_wb_addr == REG_ARG);
                rd_pend  = '0;
                if (o_wb_we && o_wb_addr == REG_CMD) cmd_ack_cyc = cyc_cnt + 1;
                if (!o_wb_we && o_wb_addr == REG_CMD) begin
                    rd_pend = (polls_seen < busy_polls) ? 32'h0000_4000 : cmd_final;
                    polls_seen++;
                end
                if (!o_wb_we && o_wb_addr == REG_ARG) rd_pend = arg_rsp;
            end
        end
        prev_stb   = o_wb_stb;
        prev_stall = wb_stall;
        prev_we    = o_wb_we;
        prev_addr  = o_wb_addr;
        prev_data  = o_wb_data;
    end

    task automatic push_op(input logic we, input logic [2:0] addr, input logic [31:0] data);
        op_q.push_back({we, addr, data});
    endtask

    task automatic push_normal(input logic [31:0] cmd, input logic [31:0] arg, input int polls);
        push_op(1'b1, REG_ARG, arg);
        push_op(1'b1, REG_CMD, cmd);
        for (int i = 0; i < polls; i++) push_op(1'b0, REG_CMD, 32'h0);
        push_op(1'b0, REG_ARG, 32'h0);
    endtask

    task automatic do_req(input logic [31:0] cmd, input logic [31:0] arg,
                          input logic [31:0] exp_data, input logic [1:0] exp_status,
                          input bit chk_data, output int lat);
        logic [34:0] exp;
        int n;
        rsp_q.push_back({chk_data, exp_data, exp_status});
        @(negedge clk);
        check("req_ready_idle", o_req_ready, 1'b1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_arg   = arg;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!o_rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        lat = n - 1;
        check("rsp_arrived", o_rsp_valid, 1'b1);
        exp = rsp_q.pop_front();
        check("rsp_status", o_rsp_status, exp[1:0]);
        if (exp[34]) check("rsp_data", o_rsp_data, exp[33:2]);
        if (ops_check) check("ops_remaining", op_q.size(), 0);
        // A second request must not be taken while the response is pending
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        check("rsp_hold", {o_rsp_valid, o_req_ready, o_wb_cyc, o_rsp_status},
              {1'b1, 1'b0, 1'b0, exp[1:0]});
        if (exp[34]) check("rsp_hold_data", o_rsp_data, exp[33:2]);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("rsp_release", {o_rsp_valid, o_req_ready, o_wb_cyc}, 3'b010);
    endtask

    initial begin
        int lat;
        int n;
        int elapsed;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_wb", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
        check("rst_rsp", {o_rsp_valid, o_rsp_data, o_rsp_status}, 35'h0);
        check("rst_sel", o_wb_sel, 4'hf);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", o_req_ready, 1'b1);
        chk_en = 1'b1;

        // Minimum latency: no stall, not busy on first poll
        test_id++;
        busy_polls = 0; cmd_final = 32'h0; arg_rsp = 32'h1234_5678;
        push_normal(32'h0000_0011, 32'h0000_abcd, 1);
        do_req(32'h0000_0011, 32'h0000_abcd, 32'h1234_5678, RSP_OK, 1'b1, lat);
        check("latency", lat, 12);

        // Busy for three polls, then done
        test_id++;
        busy_polls = 3; cmd_final = 32'h0; arg_rsp = 32'h0000_0900;
        push_normal(32'h0000_0051, 32'h0000_1000, 4);
        do_req(32'h0000_0051, 32'h0000_1000, 32'h0000_0900, RSP_OK, 1'b1, lat);

        // Same command with every op stalled for five cycles
        test_id++;
        stall_cycles = 5;
        push_normal(32'h0000_0051, 32'h0000_1000, 4);
        do_req(32'h0000_0051, 32'h0000_1000, 32'h0000_0900, RSP_OK, 1'b1, lat);
        stall_cycles = 0;

        // Command error flag set with busy clear: no ARG readback
        test_id++;
        busy_polls = 0; cmd_final = 32'h0000_8000;
        push_op(1'b1, REG_ARG, 32'h0000_0200);
        push_op(1'b1, REG_CMD, 32'h0000_0048);
        push_op(1'b0, REG_CMD, 32'h0);
        do_req(32'h0000_0048, 32'h0000_0200, 32'h0, RSP_CMDERR, 1'b0, lat);

        // Bus error on the ARG write: CMD never written
        test_id++;
        cmd_final = 32'h0; err_on_arg = 1'b1;
        push_op(1'b1, REG_ARG, 32'hdead_0001);
        do_req(32'h0000_0037, 32'hdead_0001, 32'h0, RSP_BUSERR, 1'b1, lat);
        err_on_arg = 1'b0;

        // Normal command right after the bus error
        test_id++;
        busy_polls = 1; arg_rsp = 32'h0000_0120;
        push_normal(32'h0000_0010, 32'h0000_0200, 2);
        do_req(32'h0000_0010, 32'h0000_0200, 32'h0000_0120, RSP_OK, 1'b1, lat);

        // Busy never clears: timeout
        test_id++;
        busy_polls = 32'h7fff_ffff; ops_check = 1'b0;
        do_req(32'h0000_0019, 32'h0000_0000, 32'h0, RSP_TIMEOUT, 1'b0, lat);
        elapsed = lat + 1;
        elapsed = cyc_cnt - cmd_ack_cyc;
        check("tmo_window", (elapsed >= 256 + 3) && (elapsed <= 256 + PGAP + 6), 1'b1);
        repeat (3) @(negedge clk);
        check("tmo_cyc_low", o_wb_cyc, 1'b0);

        // Reset while a poll is on the bus
        test_id++;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 32'h0000_0019; req_arg = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(o_wb_cyc && !o_wb_we && o_wb_addr == REG_CMD) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("poll_reached", o_wb_cyc && !o_wb_we && o_wb_addr == REG_CMD, 1'b1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_op", {o_wb_cyc, o_wb_stb, o_rsp_valid}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_id++;
        @(negedge clk);
        check("ready_after_rst2", o_req_ready, 1'b1);
        chk_en = 1'b1; ops_check = 1'b1;
        busy_polls = 0; cmd_final = 32'h0; arg_rsp = 32'h0000_0a5a;
        push_normal(32'h0000_0008, 32'h0000_01aa, 1);
        do_req(32'h0000_0008, 32'h0000_01aa, 32'h0000_0a5a, RSP_OK, 1'b1, lat);
        check("latency_after_rst", lat, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed %0d checks", n_assert);
        $fatal(1, "watchdog expired");
    end

endmodule
